systolic_drain_collector: RTL and testbench
===========================================

# systolic_drain_collector

Drives the systolic array's drain mode and captures the accumulator rows as they shift out of the bottom edge of the array. Repackages them as a backpressured row stream for the writeback path. The collector pauses the drain, by holding `drain_enable` low, whenever the downstream consumer stalls, so no row is lost and no FIFO is needed. It sits between the array's bottom-row vertical outputs and the unified-buffer writeback logic, and is sequenced by the top-level controller through a start/done handshake.

## Interface
- `N`, default `` `ARRAY_SIZE ``: array dimension; number of rows drained and columns per beat.
- `ACC_W`, default `` `ACC_WIDTH ``: accumulator width.
- `OUT_W`, default `` `DATA_WIDTH ``: requantized output width (used only with `DRAIN_REQUANT_EN`).
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: single-cycle pulse requesting a full N-row drain.
- `busy`, output, 1: high from the cycle after an accepted `start` until the cycle `done` pulses.
- `done`, output, 1: single-cycle pulse when the final row has been accepted downstream.
- `drain_enable`, output, 1: to the array; shifts accumulators down one row per high cycle.
- `feed_zero`, output, 1: high while in DRAIN; the top-edge weight mux injects zeros.
- `drain_data`, input, N×ACC_W signed: the array's bottom-row vertical outputs, column 0 at the LSBs.
- `shift`, input, 6: right-shift amount for requantization (ignored without the macro).
- `out_valid`, output, 1: stream valid.
- `out_ready`, input, 1: stream ready.
- `out_row`, output, $clog2(N): array row index of the current beat.
- `out_data`, output, N×ACC_W, or N×OUT_W with the macro: one row of results, column 0 at the LSBs.

## Operation
- FSM states:
  - IDLE: a `start` pulse moves the FSM to DRAIN and clears the row counter `cnt`.
  - DRAIN: on each shift beat, captures the row; moves to FLUSH on the beat where `cnt == N-1`.
  - FLUSH: waits until the output register is empty or being consumed this cycle; then pulses `done` and returns to IDLE.
- Shift beat: `drain_enable = (state==DRAIN) && (!out_valid || out_ready)`, which is combinational.
- Array contract: the row presented on `drain_data` during a cycle with `drain_enable=1` is the row leaving the array at that rising edge.
- On each shift beat, the collector registers:
  - `out_data` ← `drain_data`, or its requantized form with the macro;
  - `out_row` ← `N-1-cnt`;
  - `out_valid` ← 1;
  - `cnt` ← `cnt+1`.
- Emission order is bottom row first: rows N-1, N-2, …, 0.
- When `out_valid && out_ready` and no new beat occurs, `out_valid` ← 0.
- `out_data` and `out_row` stay stable while `out_valid && !out_ready`.
- A `start` pulse received while `busy` is ignored.
- `done` and `start` in the same cycle: the `start` is ignored.
- Exactly N shift beats and exactly N output beats occur per drain.
- `drain_enable` is never high outside DRAIN.

## Timing
- Reset values: `busy=0`, `done=0`, `drain_enable=0`, `feed_zero=0`, `out_valid=0`, `out_row=0`, `out_data=0`, FSM in IDLE, `cnt=0`.
- Start latency: `start` at edge k puts the FSM in DRAIN for cycle k+1, and `drain_enable` can be high in cycle k+1.
- Row latency: a row captured at edge e is valid from cycle e+1.
- Throughput: with `out_ready` held high, one row per cycle; N consecutive `drain_enable` cycles.
- `done` pulses in the cycle after the last row handshake; the minimum time from `start` to `done` is N+2 cycles.
- A stall of S cycles on any beat delays `done` by exactly S cycles.
- Reset asserted mid-drain: all outputs return to their reset values asynchronously. Remaining array contents are the controller's responsibility, which must clear them with `acc_clear`.

## Configuration
- `DRAIN_REQUANT_EN` defined:
  - Each column is computed as `(acc + round) >>> shift`, arithmetic, where `round = shift ? 1<<(shift-1) : 0`.
  - The sum is evaluated at ACC_W+1 bits so it cannot overflow.
  - The result saturates to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - `out_data` is N×OUT_W.
  - Requantization is combinational ahead of the output register; latency is unchanged.
- `DRAIN_REQUANT_EN` not defined: `out_data` is N×ACC_W, passed through raw, and `shift` is unused.

## Test plan
- N=4, `out_ready`=1, `drain_data` rows {40,30,20,10} replicated per column → four consecutive `drain_enable` cycles, beats `out_row` 3,2,1,0 with those values, `done` at start+6.
- `out_ready` low for 3 cycles on beat 2 → `drain_enable` low during the stall, `out_data` stable, no row dropped or duplicated, `done` delayed exactly 3 cycles.
- `start` pulsed again mid-drain and in the `done` cycle → ignored; still exactly 4 beats and a single `done`.
- `rst_n` asserted after beat 1 → all outputs return to 0 immediately; a new `start` after release yields a full 4-beat drain beginning at `out_row`=3.
- With `DRAIN_REQUANT_EN`, `shift`=4, accs {40, -40, 0x7FFFF, -0x80000} → out {3, -2, 32767, -32768}, showing round-half-up and saturation.
- Without the macro, acc values 0x7FFF_FFFF_FFFF_FFFF and -1 → passed through bit-exact.

Source files
------------

// File: rtl/systolic_drain_collector.sv
// Drain sequencer and row collector for the systolic array's bottom edge; emits rows N-1..0 as a valid/ready stream.
// Optional per-column requantization when DRAIN_REQUANT_EN is defined.
`ifndef ARRAY_SIZE
`define ARRAY_SIZE 4
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

`ifdef DRAIN_REQUANT_EN
module sdc_requant #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 16
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [5:0]       shift,
  output logic [OUT_W-1:0] q
);
  localparam logic signed [ACC_W:0] MAXV = $signed({{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W:0] MINV = ~MAXV;

  logic signed [ACC_W:0] rnd, sum, sh;

  // One extra bit of headroom so the rounding add can never wrap.
  always_comb begin
    rnd = '0;
    if (shift != 6'd0) rnd = (ACC_W+1)'(1) << (shift - 6'd1);
    sum = $signed({acc[ACC_W-1], acc}) + rnd;
    sh  = sum >>> shift;
    if (sh > MAXV)      q = MAXV[OUT_W-1:0];
    else if (sh < MINV) q = MINV[OUT_W-1:0];
    else                q = sh[OUT_W-1:0];
  end
endmodule
`endif

module systolic_drain_collector #(
  parameter int N     = `ARRAY_SIZE,
  parameter int ACC_W = `ACC_WIDTH,
  parameter int OUT_W = `DATA_WIDTH,
  localparam int RW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   drain_enable,
  output logic                   feed_zero,
  input  logic [N-1:0][ACC_W-1:0] drain_data,
  input  logic [5:0]             shift,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RW-1:0]          out_row,
`ifdef DRAIN_REQUANT_EN
  output logic [N-1:0][OUT_W-1:0] out_data
`else
  output logic [N-1:0][ACC_W-1:0] out_data
`endif
);
`ifdef DRAIN_REQUANT_EN
  localparam int DW = OUT_W;
`else
  localparam int DW = ACC_W;
`endif

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;
  typedef struct packed {
    logic [RW-1:0]          row;
    logic [N-1:0][DW-1:0]   data;
  } beat_t;

  state_t               state, state_nxt;
  logic [RW-1:0]        cnt;
  logic                 vld, beat, done_nxt, accept;
  beat_t                beat_q;
  logic [N-1:0][DW-1:0] row_d;

  for (genvar c = 0; c < N; c++) begin : g_col
`ifdef DRAIN_REQUANT_EN
    sdc_requant #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_rq (
      .acc   (drain_data[c]),
      .shift (shift),
      .q     (row_d[c])
    );
`else
    assign row_d[c] = drain_data[c];
`endif
  end

`ifndef DRAIN_REQUANT_EN
  logic unused_shift;
  assign unused_shift = ^shift;
`endif

  // The array only shifts when the output register has room, so stalls need no FIFO.
  assign beat   = (state == DRAIN) && (!vld || out_ready);
  assign accept = (state == IDLE) && start && !done;

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE:  if (accept) state_nxt = DRAIN;
      DRAIN: if (beat && cnt == RW'(N-1)) state_nxt = FLUSH;
      FLUSH: if (!vld || out_ready) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      done   <= 1'b0;
      cnt    <= '0;
      vld    <= 1'b0;
      beat_q <= '0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      if (accept)    cnt <= '0;
      else if (beat) cnt <= cnt + RW'(1);
      if (beat) begin
        vld         <= 1'b1;
        beat_q.row  <= RW'(N-1) - cnt;
        beat_q.data <= row_d;
      end else if (vld && out_ready) begin
        vld <= 1'b0;
      end
    end
  end

  // done is registered, so busy stays up through its cycle to keep a same-cycle start out.
  assign busy         = (state != IDLE) || done;
  assign drain_enable = beat;
  assign feed_zero    = (state == DRAIN);
  assign out_valid    = vld;
  assign out_row      = beat_q.row;
  assign out_data     = beat_q.data;
endmodule

// File: tb/tb_systolic_drain_collector.sv
// Bench for systolic_drain_collector: array model feeding drain_data, scoreboard of expected beats,
// table of per-row vectors plus stall / restart / reset sequences.
module tb_systolic_drain_collector;
  localparam int N = 4, ACC_W = 64, OUT_W = 16, RW = 2;
`ifdef DRAIN_REQUANT_EN
  localparam int DW = OUT_W;
`else
  localparam int DW = ACC_W;
`endif

  typedef struct {
    logic [ACC_W-1:0] acc;
    logic [5:0]       sh;
    logic [DW-1:0]    exp;
  } vec_t;
  typedef struct {
    logic [RW-1:0]        row;
    logic [N-1:0][DW-1:0] data;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b1;
  logic busy, done, drain_enable, feed_zero, out_valid;
  logic [5:0] shift = '0;
  logic [RW-1:0] out_row;
  logic [N-1:0][ACC_W-1:0] drain_data;
  logic [N-1:0][DW-1:0] out_data;

  systolic_drain_collector #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .drain_enable(drain_enable), .feed_zero(feed_zero), .drain_data(drain_data),
    .shift(shift), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_data(out_data)
  );

  always #5 clk = ~clk;

  vec_t vec [12];
  logic [N-1:0][ACC_W-1:0] arr [N];
  logic [N-1:0][DW-1:0]    exp_rows [N];
  exp_t sb [$];
  int cyc = 0, ptr = 0, de_cnt = 0;
  logic arr_load = 1'b0;
  int n_cmp = 0, n_fail = 0;

  // Array model: presents rows in leaving order, advances one row per drain_enable edge.
  assign drain_data = (ptr < N) ? arr[ptr] : '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (arr_load) begin
      ptr    <= 0;
      de_cnt <= 0;
    end else if (drain_enable) begin
      if (ptr < N) sb.push_back(exp_t'{row: RW'(N-1-ptr), data: exp_rows[ptr]});
      ptr    <= ptr + 1;
      de_cnt <= de_cnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [ACC_W-1:0] a, input logic [5:0] s, input logic [DW-1:0] e);
    vec_t v;
    v.acc = a; v.sh = s; v.exp = e;
    return v;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_de"}, drain_enable, 0);
    chk({tag, "_fz"}, feed_zero, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_row"}, out_row, 0);
    chk({tag, "_data"}, out_data, 0);
  endtask

  // Load table group g, start a drain, optionally stall on one row and poke start mid-drain / at done.
  task automatic run_drain(input int g, input int stall_row, input int stall_len, input bit extra);
    int s, got, dn, rem;
    logic held_v;
    logic [N-1:0][DW-1:0] held;
    exp_t e;
    for (int p = 0; p < N; p++)
      for (int c = 0; c < N; c++) begin
        arr[p][c]      = vec[g*N + (p+c)%N].acc;
        exp_rows[p][c] = vec[g*N + (p+c)%N].exp;
      end
    shift = vec[g*N].sh;
    sb.delete();
    @(posedge clk); #1;
    start = 1'b1; arr_load = 1'b1; out_ready = 1'b1;
    s = cyc; got = 0; dn = 0; rem = stall_len; held_v = 1'b0; held = '0;
    @(posedge clk); #1;
    arr_load = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("de_first_cycle", drain_enable, 1);
    chk("feed_zero_drain", feed_zero, 1);
    for (int i = 0; i < N + stall_len + 6; i++) begin
      start = extra && (i == 2 || done);
      if (out_valid && int'(out_row) == stall_row && rem > 0) begin
        out_ready = 1'b0; rem--;
      end else out_ready = 1'b1;
      @(negedge clk);
      if (done) begin
        dn++;
        chk("done_cycle", cyc, s + N + 2 + stall_len);
      end
      if (out_valid && !out_ready) begin
        chk("stall_de_low", drain_enable, 0);
        if (held_v) chk("stall_data_stable", out_data, held);
        held = out_data; held_v = 1'b1;
      end else held_v = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("beat_row", out_row, e.row);
          chk("beat_data", out_data, e.data);
          got++;
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("beats_total", got, N);
    chk("done_count", dn, 1);
    chk("de_count", de_cnt, N);
    chk("sb_empty", sb.size(), 0);
    chk("idle_after", busy, 0);
  endtask

  initial begin
    int got;
`ifdef DRAIN_REQUANT_EN
    vec[0]  = mk(64'd40, 6'd4, 16'd3);
    vec[1]  = mk(-64'sd40, 6'd4, -16'sd2);
    vec[2]  = mk(64'h7FFFF, 6'd4, 16'h7FFF);
    vec[3]  = mk(-64'sh80000, 6'd4, 16'h8000);
    vec[4]  = mk(64'd100, 6'd0, 16'd100);
    vec[5]  = mk(-64'sd1, 6'd0, 16'hFFFF);
    vec[6]  = mk(64'd40000, 6'd0, 16'h7FFF);
    vec[7]  = mk(-64'sd40000, 6'd0, 16'h8000);
    vec[8]  = mk(64'd3, 6'd1, 16'd2);
    vec[9]  = mk(-64'sd3, 6'd1, 16'hFFFF);
    vec[10] = mk(64'd5, 6'd1, 16'd3);
    vec[11] = mk(64'd0, 6'd1, 16'd0);
`else
    vec[0]  = mk(64'd40, 6'd0, 64'd40);
    vec[1]  = mk(64'd30, 6'd0, 64'd30);
    vec[2]  = mk(64'd20, 6'd0, 64'd20);
    vec[3]  = mk(64'd10, 6'd0, 64'd10);
    vec[4]  = mk(64'h7FFF_FFFF_FFFF_FFFF, 6'd9, 64'h7FFF_FFFF_FFFF_FFFF);
    vec[5]  = mk(64'hFFFF_FFFF_FFFF_FFFF, 6'd9, 64'hFFFF_FFFF_FFFF_FFFF);
    vec[6]  = mk(64'h8000_0000_0000_0000, 6'd9, 64'h8000_0000_0000_0000);
    vec[7]  = mk(64'h0123_4567_89AB_CDEF, 6'd9, 64'h0123_4567_89AB_CDEF);
    vec[8]  = mk(64'd5, 6'd3, 64'd5);
    vec[9]  = mk(64'd6, 6'd3, 64'd6);
    vec[10] = mk(64'd7, 6'd3, 64'd7);
    vec[11] = mk(64'd8, 6'd3, 64'd8);
`endif
    #3;
    chk_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    run_drain(0, -1, 0, 1'b0);
    run_drain(1, 2, 3, 1'b0);
    run_drain(2, -1, 0, 1'b1);

    // Reset mid-drain after the first handshake, then a clean drain.
    run_drain(0, 1, 1, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; arr_load = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; arr_load = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) got++;
      @(posedge clk); #1;
    end
    chk("reset_test_reached_beat", got, 1);
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    run_drain(1, -1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
